// File: rtl/steering_pwm.sv
// steering_pwm: PD line-follow steering with lost-line HOLD/SEARCH recovery and glitch-free servo PWM.
// Optional derivative term: define STEER_DTERM_EN to include it (default build is P-only).
module steering_pwm #(
  parameter int IMG_W        = 640,
  parameter int KP           = 4,
  parameter int KD           = 2,
  parameter int GAIN_SHIFT   = 3,
  parameter int STEER_MAX    = 500,
  parameter int PULSE_CENTER = 75000,
  parameter int PWM_PERIOD   = 1000000,
  parameter int LOST_HOLD    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(IMG_W)-1:0] centroid_x,
  input  logic                     line_valid,
  input  logic                     line_lost,
  output logic signed [10:0]       steer_cmd,
  output logic                     cmd_valid,
  output logic [1:0]               state,
  output logic                     pwm_out
);

  localparam int STAGES = 2;
  localparam int SW     = 24;
  localparam int CW     = $clog2(IMG_W);
  localparam int HC_W   = $clog2(LOST_HOLD + 1);
  localparam int CNT_W  = $clog2(PWM_PERIOD);

  localparam logic signed [SW-1:0] KP_S    = SW'(KP);
  localparam logic signed [SW-1:0] SMAX    = SW'(STEER_MAX);
  localparam logic signed [10:0]   CMD_MAX = 11'(STEER_MAX);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    HOLD   = 2'd1,
    SEARCH = 2'd2
  } state_t;

  if (PULSE_CENTER - STEER_MAX <= 0 || PULSE_CENTER + STEER_MAX >= PWM_PERIOD) begin : g_bad_pulse
    $error("steering_pwm: PULSE_CENTER +/- STEER_MAX must lie inside the PWM frame");
  end
  if (STEER_MAX < 0 || STEER_MAX > 1023) begin : g_bad_max
    $error("steering_pwm: STEER_MAX must fit the 11-bit signed command");
  end
  if (KP < 0 || KD < 0 || KP > 4095 || KD > 4095 || LOST_HOLD < 1 || IMG_W > 1024) begin : g_bad_gain
    $error("steering_pwm: gain, LOST_HOLD or IMG_W out of range");
  end

  // ---------------- stage 1: error capture ----------------
  logic [STAGES:1]   r_vld_pipe;
  logic              w_accept;
  logic signed [10:0] w_err_in;
  logic signed [10:0] r_err;
  logic              r_lost;

  // A strobe arriving while stage 1 is occupied is dropped.
  assign w_accept = line_valid & ~r_vld_pipe[1];
  assign w_err_in = $signed(11'(centroid_x)) - $signed(11'(IMG_W / 2));

  // ---------------- stage 2: PD law ----------------
  state_t              r_state, w_state_nxt;
  logic signed [10:0]  r_steer, w_steer_nxt;
  logic [HC_W-1:0]     r_hold_cnt, w_hold_nxt, w_hold_inc;
  logic                r_last_neg;
  logic                w_track_upd;
  logic signed [SW-1:0] w_err24, w_p, w_d, w_sum, w_shr;
  logic signed [10:0]  w_track, w_search_cmd;

  assign w_err24 = {{(SW-11){r_err[10]}}, r_err};
  assign w_p     = w_err24 * KP_S;

`ifdef STEER_DTERM_EN
  localparam logic signed [SW-1:0] KD_S = SW'(KD);
  logic signed [10:0]   r_prev_err;
  logic                 r_first;
  logic signed [SW-1:0] w_prev24;

  assign w_prev24 = {{(SW-11){r_prev_err[10]}}, r_prev_err};
  // The first frame after reset and any recovery frame carry no derivative kick.
  assign w_d = (r_first || r_state != TRACK) ? '0 : (w_err24 - w_prev24) * KD_S;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_err <= '0;
      r_first    <= 1'b1;
    end else begin
      if (r_vld_pipe[1]) r_first    <= 1'b0;
      if (w_track_upd)   r_prev_err <= r_err;
    end
  end
`else
  assign w_d = '0;
`endif

  assign w_sum        = w_p + w_d;
  assign w_shr        = w_sum >>> GAIN_SHIFT;
  assign w_hold_inc   = r_hold_cnt + HC_W'(1);
  assign w_search_cmd = r_last_neg ? -CMD_MAX : CMD_MAX;

  always_comb begin
    w_track = w_shr[10:0];
    if (w_shr > SMAX)       w_track = CMD_MAX;
    else if (w_shr < -SMAX) w_track = -CMD_MAX;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_steer_nxt = r_steer;
    w_hold_nxt  = r_hold_cnt;
    w_track_upd = 1'b0;
    if (r_vld_pipe[1]) begin
      if (!r_lost) begin
        w_state_nxt = TRACK;
        w_steer_nxt = w_track;
        w_hold_nxt  = '0;
        w_track_upd = 1'b1;
      end else begin
        case (r_state)
          TRACK: begin
            w_hold_nxt = HC_W'(1);
            if (LOST_HOLD <= 1) begin
              w_state_nxt = SEARCH;
              w_steer_nxt = w_search_cmd;
            end else begin
              w_state_nxt = HOLD;
            end
          end
          HOLD: begin
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc >= HC_W'(LOST_HOLD)) begin
              w_state_nxt = SEARCH;
              w_steer_nxt = w_search_cmd;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_err      <= '0;
      r_lost     <= 1'b0;
      r_state    <= TRACK;
      r_steer    <= '0;
      r_hold_cnt <= '0;
      r_last_neg <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
      if (w_accept) begin
        r_err  <= w_err_in;
        r_lost <= line_lost;
      end
      r_state    <= w_state_nxt;
      r_steer    <= w_steer_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_track_upd) r_last_neg <= r_err[10];
    end
  end

  // ---------------- servo PWM ----------------
  logic [CNT_W-1:0] r_pwm_cnt, r_pulse_w, w_pulse_new;
  logic             w_wrap, r_pwm_out;

  assign w_wrap      = (r_pwm_cnt == CNT_W'(PWM_PERIOD - 1));
  assign w_pulse_new = CNT_W'(PULSE_CENTER) + CNT_W'(r_steer);

  // Width is only sampled at the frame boundary, so a command landing on the
  // wrap cycle takes effect one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_pulse_w <= CNT_W'(PULSE_CENTER);
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_out <= (r_pwm_cnt < r_pulse_w);
      if (w_wrap) begin
        r_pwm_cnt <= '0;
        r_pulse_w <= w_pulse_new;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + CNT_W'(1);
      end
    end
  end

  assign steer_cmd = r_steer;
  assign cmd_valid = r_vld_pipe[STAGES];
  assign state     = r_state;
  assign pwm_out   = r_pwm_out;

endmodule
